// File: rtl/ratio_scale_pkg.sv
// Shared widths, latency helper and per-stage payload type for the ratio scaler pipeline.
package ratio_scale_pkg;

  localparam int unsigned RS_DATA_WIDTH = 8;
  localparam int unsigned RS_K_WIDTH    = 8;
  localparam int unsigned RS_DVD_WIDTH  = RS_DATA_WIDTH + RS_K_WIDTH;

  function automatic int unsigned lat_of(input int unsigned dw);
    return dw + 2;
  endfunction

  localparam int unsigned RS_LAT = lat_of(RS_DATA_WIDTH);

  function automatic logic [31:0] sat_all_ones(input int unsigned width);
    return (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
  endfunction

  // quo doubles as the not-yet-consumed low dividend bits; quotient bits shift in at the LSB.
  typedef struct packed {
    logic [RS_K_WIDTH-1:0]    rem;
    logic [RS_DATA_WIDTH-1:0] quo;
    logic [RS_K_WIDTH-1:0]    den;
    logic [RS_DATA_WIDTH-1:0] din;
    logic                     bypass;
    logic                     ov;
  } div_payload_t;

endpackage

// File: rtl/ratio_div_stage.sv
// One registered restoring-division step: shift in the next dividend bit, trial-subtract den,
// emit one quotient bit.
module ratio_div_stage
  import ratio_scale_pkg::*;
(
  input  logic         clk,
  input  div_payload_t pin,
  output div_payload_t pout
);

  localparam int unsigned DW = RS_DATA_WIDTH;
  localparam int unsigned KW = RS_K_WIDTH;

  logic [KW:0]  shifted;
  logic [KW:0]  diff;
  logic         ge;
  logic         unused_diff_msb;
  div_payload_t nxt;

  always_comb begin
    shifted  = {pin.rem, pin.quo[DW-1]};
    diff     = shifted - {1'b0, pin.den};
    ge       = (shifted >= {1'b0, pin.den});
    nxt      = pin;
    // When the dividend is in range the remainder stays below den, so KW bits suffice.
    nxt.rem  = ge ? diff[KW-1:0] : shifted[KW-1:0];
    nxt.quo  = {pin.quo[DW-2:0], ge};
  end

  assign unused_diff_msb = diff[KW];

  always_ff @(posedge clk) begin
    pout <= nxt;
  end

endmodule

// File: rtl/ratio_scale_pipe.sv
// Streaming per-channel q = sat(din*num/den), one pixel per clock, fixed latency DATA_WIDTH+2.
// Define RATIO_SCALE_ROUND_EN for round-half-up; otherwise the quotient is truncated.
module ratio_scale_pipe
  import ratio_scale_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RS_DATA_WIDTH,
  parameter int unsigned K_WIDTH    = RS_K_WIDTH,
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned USER_WIDTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic                           in_sof,
  input  logic                           in_bypass,
  input  logic [USER_WIDTH-1:0]          in_user,
  input  logic [CHANNELS*DATA_WIDTH-1:0] din,
  input  logic [CHANNELS*K_WIDTH-1:0]    cfg_num,
  input  logic [CHANNELS*K_WIDTH-1:0]    cfg_den,
  output logic                           out_valid,
  output logic [USER_WIDTH-1:0]          out_user,
  output logic [CHANNELS*DATA_WIDTH-1:0] q
);

  localparam int unsigned DW  = DATA_WIDTH;
  localparam int unsigned KW  = K_WIDTH;
  localparam int unsigned DVW = DW + KW;
  localparam int unsigned LAT = lat_of(DW);
  localparam logic [DW-1:0] ALL_ONES = DW'(sat_all_ones(DW));

  logic                   sof_take;
  logic [CHANNELS*KW-1:0] num_q, den_q;
  logic [CHANNELS*KW-1:0] num_use, den_use;

  // An SOF pixel already uses the coefficients presented with it.
  assign sof_take = in_valid & in_sof;
  assign num_use  = sof_take ? cfg_num : num_q;
  assign den_use  = sof_take ? cfg_den : den_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      num_q <= {CHANNELS{KW'(1)}};
      den_q <= {CHANNELS{KW'(1)}};
    end else if (sof_take) begin
      num_q <= cfg_num;
      den_q <= cfg_den;
    end
  end

  logic [LAT-1:0]        valid_q;
  logic [USER_WIDTH-1:0] user_q [LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < LAT; i++) user_q[i] <= '0;
    end else begin
      valid_q   <= {valid_q[LAT-2:0], in_valid};
      user_q[0] <= in_user;
      for (int i = 1; i < LAT; i++) user_q[i] <= user_q[i-1];
    end
  end

  assign out_valid = valid_q[LAT-1];
  assign out_user  = user_q[LAT-1];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [DW-1:0]  din_c;
    logic [KW-1:0]  num_c, den_c;
    logic [DVW-1:0] prod, dvd;
    div_payload_t   s0_d, s0_q;
    div_payload_t   stg [DW];
    logic [DW-1:0]  q_q;
    logic           unused_tail;

    assign din_c = din[c*DW +: DW];
    assign num_c = num_use[c*KW +: KW];
    assign den_c = den_use[c*KW +: KW];

    always_comb begin
      prod = DVW'(din_c) * DVW'(num_c);
`ifdef RATIO_SCALE_ROUND_EN
      dvd  = prod + DVW'(den_c >> 1);
`else
      dvd  = prod;
`endif
      s0_d.rem    = dvd[DVW-1:DW];
      s0_d.quo    = dvd[DW-1:0];
      s0_d.den    = den_c;
      s0_d.din    = din_c;
      s0_d.bypass = in_bypass;
      // A quotient that would not fit in DW bits, or a zero divisor, forces saturation.
      s0_d.ov     = (den_c == '0) || (dvd >= {den_c, {DW{1'b0}}});
    end

    always_ff @(posedge clk) begin
      s0_q <= s0_d;
    end

    for (genvar k = 0; k < DW; k++) begin : g_stage
      if (k == 0) begin : g_first
        ratio_div_stage u_stage (
          .clk  (clk),
          .pin  (s0_q),
          .pout (stg[0])
        );
      end else begin : g_next
        ratio_div_stage u_stage (
          .clk  (clk),
          .pin  (stg[k-1]),
          .pout (stg[k])
        );
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        q_q <= '0;
      end else if (valid_q[LAT-2]) begin
        q_q <= stg[DW-1].bypass ? stg[DW-1].din :
               (stg[DW-1].ov ? ALL_ONES : stg[DW-1].quo);
      end
    end

    assign q[c*DW +: DW] = q_q;
    assign unused_tail   = ^{stg[DW-1].rem, stg[DW-1].den};
  end

endmodule

// File: tb/tb_ratio_scale_pipe.sv
// Self-checking bench for ratio_scale_pipe: directed vector table, latency/reset sequences and
// random pixels against a floor (or round-half-up) division model.
`timescale 1ns/1ps
module tb_ratio_scale_pipe;

  localparam int DW   = 8;
  localparam int KW   = 8;
  localparam int CH   = 3;
  localparam int UW   = 2;
  localparam int LAT  = DW + 2;
  localparam int HIST = 2048;
`ifdef RATIO_SCALE_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_sof = 1'b0;
  logic           in_bypass = 1'b0;
  logic [UW-1:0]  in_user = '0;
  logic [CH*DW-1:0] din = '0;
  logic [CH*KW-1:0] cfg_num = '0;
  logic [CH*KW-1:0] cfg_den = '0;
  logic           out_valid;
  logic [UW-1:0]  out_user;
  logic [CH*DW-1:0] q;

  ratio_scale_pipe #(
    .DATA_WIDTH (DW),
    .K_WIDTH    (KW),
    .CHANNELS   (CH),
    .USER_WIDTH (UW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_bypass (in_bypass),
    .in_user   (in_user),
    .din       (din),
    .cfg_num   (cfg_num),
    .cfg_den   (cfg_den),
    .out_valid (out_valid),
    .out_user  (out_user),
    .q         (q)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected output per input-sampling edge index.
  bit              h_vld  [HIST];
  logic [CH*DW-1:0] h_q   [HIST];
  logic [UW-1:0]   h_user [HIST];

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  typedef struct {
    bit          sof;
    bit          byp;
    logic [1:0]  user;
    logic [23:0] num;
    logic [23:0] den;
    logic [23:0] din;
    logic [23:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit sof, input bit byp, input logic [1:0] user,
                              input logic [23:0] num, input logic [23:0] den,
                              input logic [23:0] d, input logic [23:0] exp);
    vec_t v;
    v.sof = sof; v.byp = byp; v.user = user;
    v.num = num; v.den = den; v.din = d; v.exp = exp;
    return v;
  endfunction

  function automatic logic [DW-1:0] model_ch(input logic [DW-1:0] d, input logic [KW-1:0] n,
                                             input logic [KW-1:0] dn, input bit byp);
    int unsigned p, r;
    if (byp) return d;
    if (dn == 0) return 8'hFF;
    p = 32'(d) * 32'(n);
    if (RND) p = p + 32'(dn) / 2;
    r = p / 32'(dn);
    return (r > 255) ? 8'hFF : 8'(r);
  endfunction

  // Sets inputs for the next rising edge and records what must appear LAT cycles later.
  task automatic drive(input bit vld, input bit sof, input bit byp, input logic [UW-1:0] user,
                       input logic [CH*KW-1:0] num, input logic [CH*KW-1:0] den,
                       input logic [CH*DW-1:0] d, input logic [CH*DW-1:0] exp);
    int idx;
    @(posedge clk); #1;
    in_valid = vld; in_sof = sof; in_bypass = byp; in_user = user;
    cfg_num = num; cfg_den = den; din = d;
    idx = cyc + 1;
    h_vld[idx] = vld; h_q[idx] = exp; h_user[idx] = user;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
  endtask

  always @(negedge clk) begin
    int idx;
    if (chk_en) begin
      idx = cyc - LAT + 1;
      if (idx >= 0 && idx < HIST && h_vld[idx]) begin
        check("out_valid", 64'(out_valid), 64'd1);
        check("q", 64'(q), 64'(h_q[idx]));
        check("out_user", 64'(out_user), 64'(h_user[idx]));
      end else begin
        check("out_valid_idle", 64'(out_valid), 64'd0);
      end
    end
  end

  initial begin
    vec_t        vecs [12];
    int unsigned cnt;
    bit          seen;
    int          vcount;
    int          rst_idx;
    logic [KW-1:0] cur_num [CH];
    logic [KW-1:0] cur_den [CH];

    vecs[0]  = mk(1, 0, 2'd0, {8'd2, 8'd2, 8'd2}, {8'd4, 8'd4, 8'd4}, {8'd200, 8'd100, 8'd1},
                  RND ? {8'd100, 8'd50, 8'd1} : {8'd100, 8'd50, 8'd0});
    vecs[1]  = mk(1, 0, 2'd1, {8'd1, 8'd1, 8'd255}, {8'd1, 8'd1, 8'd1}, {8'd255, 8'd7, 8'd2},
                  {8'd255, 8'd7, 8'd255});
    vecs[2]  = mk(0, 0, 2'd2, {8'd1, 8'd1, 8'd255}, {8'd1, 8'd1, 8'd1}, {8'd10, 8'd128, 8'd0},
                  {8'd10, 8'd128, 8'd0});
    vecs[3]  = mk(1, 0, 2'd3, {8'd3, 8'd5, 8'd3}, {8'd2, 8'd0, 8'd4}, {8'd10, 8'd20, 8'd40},
                  {8'd15, 8'd255, 8'd30});
    vecs[4]  = mk(0, 0, 2'd0, {8'd9, 8'd9, 8'd9}, {8'd1, 8'd1, 8'd1}, {8'd2, 8'd2, 8'd2},
                  RND ? {8'd3, 8'd255, 8'd2} : {8'd3, 8'd255, 8'd1});
    vecs[5]  = mk(0, 1, 2'd1, {8'd9, 8'd9, 8'd9}, {8'd1, 8'd1, 8'd1}, {8'h37, 8'h37, 8'h37},
                  {8'h37, 8'h37, 8'h37});
    vecs[6]  = mk(0, 0, 2'd2, {8'd9, 8'd9, 8'd9}, {8'd1, 8'd1, 8'd1}, {8'd4, 8'd4, 8'd4},
                  {8'd6, 8'd255, 8'd3});
    vecs[7]  = mk(0, 1, 2'd3, {8'd9, 8'd9, 8'd9}, {8'd1, 8'd1, 8'd1}, {8'd1, 8'd2, 8'd3},
                  {8'd1, 8'd2, 8'd3});
    vecs[8]  = mk(1, 0, 2'd0, {8'd0, 8'd0, 8'd0}, {8'd0, 8'd7, 8'd3}, {8'd50, 8'd50, 8'd50},
                  {8'd255, 8'd0, 8'd0});
    vecs[9]  = mk(1, 0, 2'd1, {8'd1, 8'd1, 8'd1}, {8'd2, 8'd2, 8'd2}, {8'd3, 8'd3, 8'd1},
                  RND ? {8'd2, 8'd2, 8'd1} : {8'd1, 8'd1, 8'd0});
    vecs[10] = mk(1, 0, 2'd2, {8'd255, 8'd255, 8'd255}, {8'd255, 8'd255, 8'd255},
                  {8'd255, 8'd0, 8'd128}, {8'd255, 8'd0, 8'd128});
    vecs[11] = mk(1, 0, 2'd3, {8'd200, 8'd1, 8'd16}, {8'd3, 8'd255, 8'd1},
                  {8'd17, 8'd200, 8'd15}, RND ? {8'd255, 8'd1, 8'd240} : {8'd255, 8'd0, 8'd240});

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_q", 64'(q), 64'd0);
    check("reset_out_user", 64'(out_user), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk_en = 1'b1;

    // Directed table, back to back
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].sof, vecs[i].byp, vecs[i].user, vecs[i].num, vecs[i].den,
            vecs[i].din, vecs[i].exp);
    end
    idle(LAT + 2);

    // Isolated pixel: first out_valid must be exactly LAT cycles after it is sampled
    drive(1'b1, 1'b1, 1'b0, 2'd3, {8'd2, 8'd2, 8'd2}, {8'd4, 8'd4, 8'd4},
          {8'd200, 8'd100, 8'd1}, RND ? {8'd100, 8'd50, 8'd1} : {8'd100, 8'd50, 8'd0});
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
    cnt = 1; seen = 1'b0;
    while (!seen && cnt < 30) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        cnt++;
      end
    end
    check("latency", 64'(cnt), 64'(LAT));
    idle(LAT + 2);

    // Random pixels; cfg is random every cycle so non-SOF changes must be ignored
    for (int i = 0; i < 1000; i++) begin
      bit v, s, b;
      logic [CH*KW-1:0] n, dn;
      logic [CH*DW-1:0] d, e;
      v = (i == 0) || ($urandom_range(0, 4) != 0);
      s = (i == 0) || ($urandom_range(0, 15) == 0);
      b = ($urandom_range(0, 3) == 0);
      d = 24'($urandom);
      for (int c = 0; c < CH; c++) begin
        n[c*KW +: KW]  = 8'($urandom_range(0, 255) >> $urandom_range(0, 4));
        dn[c*KW +: KW] = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      end
      if (v && s) begin
        for (int c = 0; c < CH; c++) begin
          cur_num[c] = n[c*KW +: KW];
          cur_den[c] = dn[c*KW +: KW];
        end
      end
      for (int c = 0; c < CH; c++) begin
        e[c*DW +: DW] = model_ch(d[c*DW +: DW], cur_num[c], cur_den[c], b);
      end
      drive(v, s, b, 2'($urandom), n, dn, d, e);
    end
    idle(LAT + 2);

    // Reset with five pixels in flight: none may emerge
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 2'd1, '0, '0, {8'd5, 8'd5, 8'd5}, {8'd5, 8'd5, 8'd5});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    in_valid = 1'b1;
    rst_idx = cyc + 1;
    for (int j = rst_idx - LAT + 1; j <= rst_idx; j++) h_vld[j] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b0;
    vcount = 0;
    repeat (LAT + 2) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    check("flush_after_reset", 64'(vcount), 64'd0);

    // Coefficients return to identity after reset; non-SOF cfg is ignored
    drive(1'b1, 1'b0, 1'b0, 2'd1, 24'hFFFFFF, 24'h000000, {8'd9, 8'd8, 8'd7},
          {8'd9, 8'd8, 8'd7});
    idle(LAT + 3);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
